// File: rtl/lsu_ctrl_if.sv
// Request, data-memory and writeback signals between the execute stage, lsu_ctrl and data memory.
// The slave modport is the lsu_ctrl side; master is the environment (execute stage plus memory).
interface lsu_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic [DATA_W-1:0] req_base;
  logic [OFF_W-1:0]  req_off;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;

  logic              mem_r_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err;
  logic              stall;

  modport slave (
    input  req_valid, req_load, req_base, req_off, req_wdata, req_rd, mem_rdata,
    output req_ready, stall, mem_r_en, mem_w_en, mem_adr, mem_wdata,
           wb_valid, wb_rd, wb_data, err
  );

  modport master (
    output req_valid, req_load, req_base, req_off, req_wdata, req_rd, mem_rdata,
    input  req_ready, stall, mem_r_en, mem_w_en, mem_adr, mem_wdata,
           wb_valid, wb_rd, wb_data, err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage: computes base + sext(offset), sequences the data memory's
// enables around its one-cycle read latency and returns load data to writeback.
module lsu_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int OFF_W  = 16
) (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WB,
    S_WR,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic [DATA_W-1:0] mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [4:0]        rd_q, rd_d;

  logic [DATA_W-1:0] ea;
  logic              ea_out_of_range;

  assign ea              = bus.req_base + {{(DATA_W-OFF_W){bus.req_off[OFF_W-1]}}, bus.req_off};
  assign ea_out_of_range = |ea[DATA_W-1:ADDR_W];

  // Every output value is decided one cycle ahead so that the mem_*, wb_* and err
  // ports come straight from flops rather than from the req_* inputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    mem_r_en_d  = 1'b0;
    mem_w_en_d  = 1'b0;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    rd_d        = rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          rd_d = bus.req_rd;
          if (ea_out_of_range) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (bus.req_load) begin
            state_d    = S_RD;
            mem_r_en_d = 1'b1;
            mem_adr_d  = ea;
          end else begin
            state_d     = S_WR;
            mem_w_en_d  = 1'b1;
            mem_adr_d   = ea;
            mem_wdata_d = bus.req_wdata;
          end
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        // Memory data for the RD-cycle address is valid now; capture it for writeback.
        state_d    = S_WB;
        wb_valid_d = 1'b1;
        wb_data_d  = bus.mem_rdata;
        wb_rd_d    = rd_q;
      end
      S_WB, S_WR, S_ERR: state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_r_en_q  <= mem_r_en_d;
      mem_w_en_q  <= mem_w_en_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.stall     = (state_q != S_IDLE);
  assign bus.mem_r_en  = mem_r_en_q;
  assign bus.mem_w_en  = mem_w_en_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: 8-word data memory model with one-cycle registered read,
// event counters on the falling edge, and one task per scenario.
module tb_lsu_ctrl;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 16;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  lsu_ctrl_if #(.DATA_W(DATA_W), .OFF_W(OFF_W)) bus ();

  lsu_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: word 5 holds 1, every other word holds its own index.
  logic [DATA_W-1:0] mem [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd6, 32'd7};
  logic [DATA_W-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (bus.mem_w_en && bus.mem_adr < 8) mem[bus.mem_adr[2:0]] <= bus.mem_wdata;
    if (bus.mem_r_en) rdata_q <= mem[bus.mem_adr[2:0]];
  end
  assign bus.mem_rdata = rdata_q;

  int n_r = 0, n_w = 0, n_wb = 0, n_err = 0, n_ovl = 0, n_stall = 0;
  always @(negedge clk) begin
    if (bus.mem_r_en === 1'b1) n_r <= n_r + 1;
    if (bus.mem_w_en === 1'b1) n_w <= n_w + 1;
    if (bus.wb_valid === 1'b1) n_wb <= n_wb + 1;
    if (bus.err === 1'b1) n_err <= n_err + 1;
    if (bus.mem_r_en === 1'b1 && bus.mem_w_en === 1'b1) n_ovl <= n_ovl + 1;
    if (bus.stall !== ~bus.req_ready) n_stall <= n_stall + 1;
  end

  int s_r, s_w, s_wb, s_err, s_ovl, s_stall;
  task automatic snap();
    s_r = n_r; s_w = n_w; s_wb = n_wb; s_err = n_err; s_ovl = n_ovl; s_stall = n_stall;
  endtask

  // Present a request and wait (bounded) for the accepting edge; returns at edge+1.
  task automatic accept(input logic ld, input logic [DATA_W-1:0] base,
                        input logic [OFF_W-1:0] off, input logic [DATA_W-1:0] wd,
                        input logic [4:0] rd, input logic hold);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_load = ld; bus.req_base = base;
    bus.req_off = off; bus.req_wdata = wd; bus.req_rd = rd;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL accept_wait: req_ready=%b required 1 within 20 cycles", bus.req_ready);
    end
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #13 rst = 1'b0;
    #1;
    total++;
    if ({bus.mem_r_en, bus.mem_w_en, bus.wb_valid, bus.err, bus.stall, bus.req_ready} !== 6'b000001) begin
      bad++; $display("FAIL reset_ctrl: r_en,w_en,wb_valid,err,stall,ready=%b required 000001",
        {bus.mem_r_en, bus.mem_w_en, bus.wb_valid, bus.err, bus.stall, bus.req_ready});
    end
    total++;
    if ({bus.mem_adr, bus.mem_wdata, bus.wb_data, bus.wb_rd} !== '0) begin
      bad++; $display("FAIL reset_data: adr=%h wdata=%h wb_data=%h wb_rd=%0d required all 0",
        bus.mem_adr, bus.mem_wdata, bus.wb_data, bus.wb_rd);
    end
    @(negedge clk); rst = 1'b1;
    snap();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin
      bad++; $display("FAIL reset_idle: ready=%b stall=%b required 1/0", bus.req_ready, bus.stall);
    end
    total++;
    if (n_r - s_r + n_w - s_w + n_err - s_err != 0) begin
      bad++; $display("FAIL reset_no_enables: %0d enable/err cycles required 0",
        n_r - s_r + n_w - s_w + n_err - s_err);
    end
  endtask

  task automatic test_load();
    snap();
    accept(1'b1, 32'd2, 16'd3, 32'd0, 5'd9, 1'b0);
    total++;
    if ({bus.mem_r_en, bus.mem_w_en, bus.stall, bus.req_ready} !== 4'b1010 || bus.mem_adr !== 32'd5) begin
      bad++; $display("FAIL load_rd: r,w,stall,ready=%b adr=%h required 1010 adr=5",
        {bus.mem_r_en, bus.mem_w_en, bus.stall, bus.req_ready}, bus.mem_adr);
    end
    @(posedge clk); #1;
    total++;
    if ({bus.mem_r_en, bus.wb_valid, bus.stall} !== 3'b001) begin
      bad++; $display("FAIL load_wait: r_en,wb_valid,stall=%b required 001",
        {bus.mem_r_en, bus.wb_valid, bus.stall});
    end
    @(posedge clk); #1;
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1 || bus.wb_rd !== 5'd9 || bus.stall !== 1'b1) begin
      bad++; $display("FAIL load_wb: wb_valid=%b data=%h rd=%0d stall=%b required 1 00000001 9 1",
        bus.wb_valid, bus.wb_data, bus.wb_rd, bus.stall);
    end
    @(posedge clk); #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.wb_data !== 32'h1) begin
      bad++; $display("FAIL load_done: ready=%b wb_valid=%b data=%h required 1 0 00000001",
        bus.req_ready, bus.wb_valid, bus.wb_data);
    end
    total++;
    if (n_r - s_r != 1 || n_wb - s_wb != 1 || n_w - s_w != 0 || n_err - s_err != 0) begin
      bad++; $display("FAIL load_counts: r=%0d wb=%0d w=%0d err=%0d required 1 1 0 0",
        n_r - s_r, n_wb - s_wb, n_w - s_w, n_err - s_err);
    end
  endtask

  task automatic test_store();
    snap();
    accept(1'b0, 32'd7, 16'hFFFF, 32'hDEADBEEF, 5'd0, 1'b0);
    total++;
    if ({bus.mem_w_en, bus.mem_r_en, bus.stall} !== 3'b101 || bus.mem_adr !== 32'd6 ||
        bus.mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_wr: w,r,stall=%b adr=%h wdata=%h required 101 6 deadbeef",
        {bus.mem_w_en, bus.mem_r_en, bus.stall}, bus.mem_adr, bus.mem_wdata);
    end
    @(posedge clk); #1;
    total++;
    if (bus.mem_w_en !== 1'b0 || bus.req_ready !== 1'b1 || mem[6] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_done: w_en=%b ready=%b mem6=%h required 0 1 deadbeef",
        bus.mem_w_en, bus.req_ready, mem[6]);
    end
    accept(1'b1, 32'd6, 16'd0, 32'd0, 5'd1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL store_readback: wb_valid=%b data=%h required 1 deadbeef",
        bus.wb_valid, bus.wb_data);
    end
    @(posedge clk); #1;
    total++;
    if (n_w - s_w != 1 || n_wb - s_wb != 1) begin
      bad++; $display("FAIL store_counts: w=%0d wb=%0d required 1 1 (wb from readback only)",
        n_w - s_w, n_wb - s_wb);
    end
  endtask

  task automatic test_out_of_range();
    snap();
    accept(1'b1, 32'd6, 16'd2, 32'd0, 5'd4, 1'b0);
    total++;
    if ({bus.err, bus.mem_r_en, bus.mem_w_en} !== 3'b100 || bus.mem_adr !== 32'd6) begin
      bad++; $display("FAIL oor_ea8: err,r,w=%b adr=%h required 100 adr held 6",
        {bus.err, bus.mem_r_en, bus.mem_w_en}, bus.mem_adr);
    end
    @(posedge clk); #1;
    total++;
    if (bus.err !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL oor_ea8_done: err=%b ready=%b required 0 1", bus.err, bus.req_ready);
    end
    accept(1'b0, 32'd0, 16'hFFFF, 32'h12345678, 5'd0, 1'b0);
    total++;
    if ({bus.err, bus.mem_r_en, bus.mem_w_en} !== 3'b100 || bus.mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL oor_neg: err,r,w=%b wdata=%h required 100 wdata held deadbeef",
        {bus.err, bus.mem_r_en, bus.mem_w_en}, bus.mem_wdata);
    end
    @(posedge clk); #1;
    total++;
    if (n_err - s_err != 2 || n_r - s_r != 0 || n_w - s_w != 0 || n_wb - s_wb != 0) begin
      bad++; $display("FAIL oor_counts: err=%0d r=%0d w=%0d wb=%0d required 2 0 0 0",
        n_err - s_err, n_r - s_r, n_w - s_w, n_wb - s_wb);
    end
  endtask

  task automatic test_back_to_back();
    int first_w = 0, wb_at = 0, busy_bad = 0;
    logic [DATA_W-1:0] wb_seen = '0;
    snap();
    accept(1'b1, 32'd0, 16'd1, 32'd0, 5'd3, 1'b1);
    bus.req_load = 1'b0; bus.req_base = 32'd0; bus.req_off = 16'd2; bus.req_wdata = 32'hA5A5A5A5;
    for (int k = 1; k <= 8 && first_w == 0; k++) begin
      @(posedge clk); #1;
      if (k <= 2 && bus.stall !== 1'b1) busy_bad++;
      if (bus.wb_valid === 1'b1) begin wb_at = k; wb_seen = bus.wb_data; end
      if (bus.mem_w_en === 1'b1) first_w = k;
    end
    bus.req_valid = 1'b0;
    total++;
    if (first_w != 4) begin
      bad++; $display("FAIL b2b_accept: store enable seen %0d cycles after load accept, required 4", first_w);
    end
    total++;
    if (wb_at != 2 || wb_seen !== 32'h1 || busy_bad != 0) begin
      bad++; $display("FAIL b2b_load: wb at %0d data=%h busy_stall_bad=%0d required 2 00000001 0",
        wb_at, wb_seen, busy_bad);
    end
    @(posedge clk); #1;
    total++;
    if (mem[2] !== 32'hA5A5A5A5 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_store: mem2=%h ready=%b required a5a5a5a5 1", mem[2], bus.req_ready);
    end
    total++;
    if (n_ovl - s_ovl != 0 || n_stall - s_stall != 0 || n_r - s_r != 1 || n_w - s_w != 1) begin
      bad++; $display("FAIL b2b_counts: overlap=%0d stall_vs_ready=%0d r=%0d w=%0d required 0 0 1 1",
        n_ovl - s_ovl, n_stall - s_stall, n_r - s_r, n_w - s_w);
    end
  endtask

  task automatic test_reset_in_wait();
    accept(1'b1, 32'd3, 16'd0, 32'd0, 5'd7, 1'b0);
    @(posedge clk); #1;
    total++;
    if (bus.mem_r_en !== 1'b0 || bus.stall !== 1'b1) begin
      bad++; $display("FAIL rstwait_state: r_en=%b stall=%b required 0 1", bus.mem_r_en, bus.stall);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0 || bus.wb_data !== '0 || bus.wb_rd !== '0) begin
      bad++; $display("FAIL rstwait_async: ready=%b wb_valid=%b data=%h rd=%0d required 1 0 0 0",
        bus.req_ready, bus.wb_valid, bus.wb_data, bus.wb_rd);
    end
    snap();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (n_wb - s_wb != 0 || n_err - s_err != 0) begin
      bad++; $display("FAIL rstwait_no_wb: wb=%0d err=%0d after reset, required 0 0",
        n_wb - s_wb, n_err - s_err);
    end
    accept(1'b1, 32'd4, 16'd0, 32'd0, 5'd12, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h4 || bus.wb_rd !== 5'd12) begin
      bad++; $display("FAIL rstwait_reload: wb_valid=%b data=%h rd=%0d required 1 00000004 12",
        bus.wb_valid, bus.wb_data, bus.wb_rd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_base = '0;
    bus.req_off = '0; bus.req_wdata = '0; bus.req_rd = '0;
    test_reset();
    test_load();
    test_store();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
